// File: rtl/pla_seq_eval.sv
// Runtime-loadable PLA: AND/OR planes written through a config port, product terms
// swept TERMS_PER_CYCLE per clock. Optional fired-term counter: PLA_SEQ_HIT_COUNT_EN.
module pla_seq_eval #(
  parameter int N_IN            = 19,
  parameter int N_OUT           = 10,
  parameter int N_TERMS         = 64,
  parameter int TERMS_PER_CYCLE = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(N_TERMS)-1:0]   cfg_addr,
  input  logic [2*N_IN-1:0]            cfg_and,
  input  logic [N_OUT-1:0]             cfg_or,
  input  logic                         cfg_nterms_we,
  input  logic [$clog2(N_TERMS):0]     cfg_nterms,
  output logic                         cfg_ready,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN-1:0]              in_x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OUT-1:0]             out_z,
  output logic                         busy
`ifdef PLA_SEQ_HIT_COUNT_EN
  ,
  output logic [$clog2(N_TERMS):0]     out_hits
`endif
);

  localparam int AW = $clog2(N_TERMS);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t                r_state;
  logic [2*N_IN-1:0]     r_and [N_TERMS];
  logic [N_OUT-1:0]      r_or  [N_TERMS];
  logic [CW-1:0]         r_nterms;
  logic [CW-1:0]         r_ptr;
  logic [N_IN-1:0]       r_x;
  logic [N_OUT-1:0]      r_acc;
  logic [N_OUT-1:0]      r_out_z;
  logic                  r_out_valid;

  logic [TERMS_PER_CYCLE-1:0] w_fire;
  logic [N_OUT-1:0]           w_slice_or;
  logic                       w_last;

  // A 2'b00 pair has neither bit set, so it can never match and kills the term.
  function automatic logic term_fires(input logic [2*N_IN-1:0] cube,
                                      input logic [N_IN-1:0]   x);
    logic m;
    m = 1'b1;
    for (int i = 0; i < N_IN; i++)
      m = m & ((cube[2*i+1] & x[i]) | (cube[2*i] & ~x[i]));
    return m;
  endfunction

  always_comb begin
    w_fire     = '0;
    w_slice_or = '0;
    for (int k = 0; k < TERMS_PER_CYCLE; k++) begin
      if ((r_ptr + CW'(k)) < r_nterms)
        w_fire[k] = term_fires(r_and[r_ptr[AW-1:0] + AW'(k)], r_x);
      if (w_fire[k])
        w_slice_or = w_slice_or | r_or[r_ptr[AW-1:0] + AW'(k)];
    end
  end

  // Covers nterms=0 as well: the first slice is then already the last one.
  assign w_last = (r_ptr + CW'(TERMS_PER_CYCLE)) >= r_nterms;

`ifdef PLA_SEQ_HIT_COUNT_EN
  logic [CW-1:0] w_slice_hits;
  logic [CW-1:0] r_hits_acc;
  logic [CW-1:0] r_out_hits;

  always_comb begin
    w_slice_hits = '0;
    for (int k = 0; k < TERMS_PER_CYCLE; k++)
      w_slice_hits = w_slice_hits + CW'(w_fire[k]);
  end

  assign out_hits = r_out_hits;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_nterms    <= '0;
      r_ptr       <= '0;
      r_x         <= '0;
      r_acc       <= '0;
      r_out_z     <= '0;
      r_out_valid <= 1'b0;
      for (int t = 0; t < N_TERMS; t++) begin
        r_and[t] <= '0;
        r_or[t]  <= '0;
      end
`ifdef PLA_SEQ_HIT_COUNT_EN
      r_hits_acc <= '0;
      r_out_hits <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (cfg_we) begin
            r_and[cfg_addr] <= cfg_and;
            r_or[cfg_addr]  <= cfg_or;
          end
          if (cfg_nterms_we)
            r_nterms <= (cfg_nterms > CW'(N_TERMS)) ? CW'(N_TERMS) : cfg_nterms;
          if (in_valid) begin
            r_x     <= in_x;
            r_acc   <= '0;
            r_ptr   <= '0;
            r_state <= EVAL;
`ifdef PLA_SEQ_HIT_COUNT_EN
            r_hits_acc <= '0;
`endif
          end
        end
        EVAL: begin
          if (w_last) begin
            r_out_z     <= r_acc | w_slice_or;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
`ifdef PLA_SEQ_HIT_COUNT_EN
            r_out_hits <= r_hits_acc + w_slice_hits;
`endif
          end else begin
            r_acc <= r_acc | w_slice_or;
            r_ptr <= r_ptr + CW'(TERMS_PER_CYCLE);
`ifdef PLA_SEQ_HIT_COUNT_EN
            r_hits_acc <= r_hits_acc + w_slice_hits;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign cfg_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;

endmodule
